// File: rtl/mmix_defs_pkg.sv
// Shared MMIX core definitions: memory arbiter state/owner types and access-size codes.
package mmix_defs;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } arb_owner_t;

  localparam logic [1:0] DS_BYTE  = 2'd0;
  localparam logic [1:0] DS_WYDE  = 2'd1;
  localparam logic [1:0] DS_TETRA = 2'd2;
  localparam logic [1:0] DS_OCTA  = 2'd3;

  function automatic logic [3:0] starve_inc(input logic [3:0] cnt, input logic [3:0] limit);
    return (cnt >= limit) ? limit : cnt + 4'd1;
  endfunction

endpackage

// File: rtl/mem_arb_watchdog.sv
// Busy-cycle watchdog for the memory arbiter; expire flags LIMIT-1 counted cycles since clear.
module mem_arb_watchdog #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CntW = (LIMIT > 2) ? $clog2(LIMIT) : 1;

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expire = (cnt_q == CntW'(LIMIT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Memory port arbiter: shares the core memory port between fetch (i_*) and load/store (d_*).
// Defining MEM_ARB_TIMEOUT_EN adds a watchdog that aborts a stalled transaction with err.
module mem_arbiter
  import mmix_defs::*;
#(
  parameter int unsigned STARVE_LIMIT   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [63:0] i_address,
  input  logic [1:0]  i_datasize,
  input  logic        i_read,
  output logic [63:0] i_readdata,
  output logic        i_done,
  input  logic [63:0] d_address,
  input  logic [1:0]  d_datasize,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [63:0] d_writedata,
  output logic [63:0] d_readdata,
  output logic        d_done,
  output logic [63:0] mem_address,
  output logic [1:0]  mem_datasize,
  output logic        mem_read,
  output logic        mem_write,
  output logic [63:0] mem_writedata,
  input  logic [63:0] mem_readdata,
  input  logic        mem_done,
  output logic        owner,
  output logic        busy,
  output logic        err
);

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("mem_arbiter: STARVE_LIMIT must be 1..15 and TIMEOUT_CYCLES at least 2");
  end

  localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

  arb_state_t  state_q, state_d;
  arb_owner_t  owner_q, owner_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        rd_q, rd_d;
  logic        wr_q, wr_d;
  logic [63:0] addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] i_rdata_q, i_rdata_d;
  logic [63:0] d_rdata_q, d_rdata_d;
  logic [1:0]  size_q, size_d;
  logic [3:0]  starve_q, starve_d;
  logic        d_req, grant, fetch_win;

  assign d_req     = d_read | d_write;
  assign grant     = (state_q == IDLE) && (i_read || d_req);
  assign fetch_win = i_read && (!d_req || (starve_q == StarveMax));

`ifdef MEM_ARB_TIMEOUT_EN
  logic err_q, err_d, wd_expire;

  mem_arb_watchdog #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (grant),
    .enable (state_q == BUSY),
    .expire (wd_expire)
  );

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rd_d      = rd_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    size_d    = size_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    starve_d  = starve_q;
`ifdef MEM_ARB_TIMEOUT_EN
    err_d     = 1'b0;
`endif
    unique case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = BUSY;
          busy_d  = 1'b1;
          if (fetch_win) begin
            owner_d  = OWN_FETCH;
            addr_d   = i_address;
            size_d   = i_datasize;
            rd_d     = 1'b1;
            wr_d     = 1'b0;
            starve_d = '0;
          end else begin
            owner_d  = OWN_DATA;
            addr_d   = d_address;
            size_d   = d_datasize;
            wdata_d  = d_writedata;
            // A simultaneous read and write performs only the read.
            rd_d     = d_read;
            wr_d     = ~d_read;
            starve_d = i_read ? starve_inc(starve_q, StarveMax) : 4'd0;
          end
        end
      end
      BUSY: begin
        if (mem_done) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          done_d  = 1'b1;
          state_d = RESP;
          if (rd_q) begin
            if (owner_q == OWN_FETCH) i_rdata_d = mem_readdata;
            else                      d_rdata_d = mem_readdata;
          end
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (wd_expire) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = RESP;
          if (owner_q == OWN_FETCH) i_rdata_d = '0;
          else                      d_rdata_d = '0;
        end
`endif
      end
      RESP: begin
        // No arbitration on this edge, so the finishing requester's level is not re-granted.
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      owner_q   <= OWN_FETCH;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      size_q    <= DS_BYTE;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      starve_q  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      size_q    <= size_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      starve_q  <= starve_d;
`ifdef MEM_ARB_TIMEOUT_EN
      err_q     <= err_d;
`endif
    end
  end

  assign mem_address   = addr_q;
  assign mem_datasize  = size_q;
  assign mem_read      = rd_q;
  assign mem_write     = wr_q;
  assign mem_writedata = wdata_q;
  assign i_readdata    = i_rdata_q;
  assign d_readdata    = d_rdata_q;
  assign i_done        = done_q && (owner_q == OWN_FETCH);
  assign d_done        = done_q && (owner_q == OWN_DATA);
  assign owner         = owner_q;
  assign busy          = busy_q;

endmodule
